// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM arbiter: default memory map,
// FSM state encoding and byte-strobe constants.
package mem_arbiter_pkg;

    localparam logic [31:0] AddrBaseDefault     = 32'h1c00_0000;
    localparam int unsigned MemWordsLog2Default = 17;
    localparam int unsigned StarveLimitDefault  = 4;

    localparam logic [3:0] WstrbFull = 4'b1111;
    localparam logic [3:0] WstrbNone = 4'b0000;

    typedef enum logic {
        StIdle,
        StRmwWr
    } arb_state_e;

endpackage

// File: rtl/wstrb_merge.sv
// Byte-lane merge for partial stores: lanes with a set strobe take the new
// word, all other lanes keep the word read back from RAM.
module wstrb_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  wstrb,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between an instruction fetch port and a load/store
// port, with data priority, fetch starvation relief and read-modify-write stores.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE      = AddrBaseDefault,
    parameter int unsigned MEM_WORDS_LOG2 = MemWordsLog2Default,
    parameter int unsigned STARVE_LIMIT   = StarveLimitDefault
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic                      inst_req_i,
    input  logic [31:0]               inst_addr_i,
    output logic                      inst_gnt_o,
    output logic                      inst_rvalid_o,
    output logic [31:0]               inst_rdata_o,
    output logic                      inst_err_o,
    input  logic                      flush_i,

    input  logic                      data_req_i,
    input  logic                      data_we_i,
    input  logic [3:0]                data_wstrb_i,
    input  logic [31:0]               data_addr_i,
    input  logic [31:0]               data_wdata_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    output logic [31:0]               data_rdata_o,
    output logic                      data_err_o,

    output logic                      ram_en_o,
    output logic                      ram_we_o,
    output logic [MEM_WORDS_LOG2-1:0] ram_addr_o,
    output logic [31:0]               ram_wdata_o,
    input  logic [31:0]               ram_rdata_i
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);
    localparam logic [32:0] ByteSpan = 33'd1 << (MEM_WORDS_LOG2 + 2);

    arb_state_e state_q, state_d;
    logic [CntW-1:0] starve_q, starve_d;

    logic inst_pend_q, inst_err_q;
    logic data_pend_q, data_err_q, data_rd_q;
    logic [MEM_WORDS_LOG2-1:0] rmw_addr_q;
    logic [31:0] rmw_wdata_q;
    logic [3:0] rmw_wstrb_q;

    logic [31:0] inst_off, data_off;
    logic inst_bad, data_bad;
    logic [MEM_WORDS_LOG2-1:0] inst_idx, data_idx;
    logic [31:0] merged_word;

    logic inst_gnt, data_gnt;
    logic ram_en, ram_we;
    logic [MEM_WORDS_LOG2-1:0] ram_addr;
    logic [31:0] ram_wdata;
    logic inst_rvalid, data_rvalid;

    // Offsets wrap modulo 2^32; addresses below the base are caught separately.
    assign inst_off = inst_addr_i - ADDR_BASE;
    assign data_off = data_addr_i - ADDR_BASE;
    assign inst_idx = inst_off[MEM_WORDS_LOG2+1:2];
    assign data_idx = data_off[MEM_WORDS_LOG2+1:2];

    assign inst_bad = (inst_addr_i[1:0] != 2'b00) || (inst_addr_i < ADDR_BASE) ||
                      ({1'b0, inst_off} >= ByteSpan);
    assign data_bad = (data_addr_i[1:0] != 2'b00) || (data_addr_i < ADDR_BASE) ||
                      ({1'b0, data_off} >= ByteSpan);

    wstrb_merge u_wstrb_merge (
        .old_word (ram_rdata_i),
        .new_word (rmw_wdata_q),
        .wstrb    (rmw_wstrb_q),
        .merged   (merged_word)
    );

    always_comb begin
        state_d   = state_q;
        inst_gnt  = 1'b0;
        data_gnt  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (inst_req_i && !flush_i && (starve_q == StarveMax || !data_req_i)) begin
                    inst_gnt = 1'b1;
                end else if (data_req_i) begin
                    data_gnt = 1'b1;
                end

                if (inst_gnt && !inst_bad) begin
                    ram_en   = 1'b1;
                    ram_addr = inst_idx;
                end

                if (data_gnt && !data_bad) begin
                    if (!data_we_i) begin
                        ram_en   = 1'b1;
                        ram_addr = data_idx;
                    end else if (data_wstrb_i == WstrbFull) begin
                        ram_en    = 1'b1;
                        ram_we    = 1'b1;
                        ram_addr  = data_idx;
                        ram_wdata = data_wdata_i;
                    end else if (data_wstrb_i != WstrbNone) begin
                        ram_en   = 1'b1;
                        ram_addr = data_idx;
                        state_d  = StRmwWr;
                    end
                end
            end
            StRmwWr: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = rmw_addr_q;
                ram_wdata = merged_word;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!inst_req_i || inst_gnt) begin
            starve_d = '0;
        end else if (starve_q != StarveMax) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            inst_pend_q <= 1'b0;
            inst_err_q  <= 1'b0;
            data_pend_q <= 1'b0;
            data_err_q  <= 1'b0;
            data_rd_q   <= 1'b0;
            rmw_addr_q  <= '0;
            rmw_wdata_q <= '0;
            rmw_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            inst_pend_q <= inst_gnt;
            inst_err_q  <= inst_gnt && inst_bad;
            data_pend_q <= data_gnt;
            data_err_q  <= data_gnt && data_bad;
            data_rd_q   <= data_gnt && !data_we_i && !data_bad;
            if (data_gnt) begin
                rmw_addr_q  <= data_idx;
                rmw_wdata_q <= data_wdata_i;
                rmw_wstrb_q <= data_wstrb_i;
            end
        end
    end

    // Every output is forced low while reset is high, which also aborts a pending RMW write.
    assign inst_rvalid = inst_pend_q && !flush_i && !reset;
    assign data_rvalid = data_pend_q && !reset;

    assign inst_gnt_o    = inst_gnt && !reset;
    assign inst_rvalid_o = inst_rvalid;
    assign inst_err_o    = inst_rvalid && inst_err_q;
    assign inst_rdata_o  = (inst_rvalid && !inst_err_q) ? ram_rdata_i : '0;

    assign data_gnt_o    = data_gnt && !reset;
    assign data_rvalid_o = data_rvalid;
    assign data_err_o    = data_rvalid && data_err_q;
    assign data_rdata_o  = (data_rvalid && data_rd_q) ? ram_rdata_i : '0;

    assign ram_en_o    = ram_en && !reset;
    assign ram_we_o    = ram_we && !reset;
    assign ram_addr_o  = reset ? '0 : ram_addr;
    assign ram_wdata_o = reset ? '0 : ram_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of arbitration and memory contents.
module tb_mem_arbiter;

    localparam logic [31:0] Base  = 32'h1c00_0000;
    localparam int unsigned Log2  = 8;
    localparam int unsigned Depth = 256;
    localparam int unsigned Limit = 4;

    logic clock, reset;
    logic inst_req_i, inst_gnt_o, inst_rvalid_o, inst_err_o, flush_i;
    logic [31:0] inst_addr_i, inst_rdata_o;
    logic data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
    logic [3:0] data_wstrb_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic ram_en_o, ram_we_o;
    logic [Log2-1:0] ram_addr_o;
    logic [31:0] ram_wdata_o, ram_rdata_i;

    logic [31:0] mem [Depth];
    logic bd_we;
    logic [Log2-1:0] bd_idx;
    logic [31:0] bd_data;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(
        .ADDR_BASE      (Base),
        .MEM_WORDS_LOG2 (Log2),
        .STARVE_LIMIT   (Limit)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .inst_req_i    (inst_req_i),
        .inst_addr_i   (inst_addr_i),
        .inst_gnt_o    (inst_gnt_o),
        .inst_rvalid_o (inst_rvalid_o),
        .inst_rdata_o  (inst_rdata_o),
        .inst_err_o    (inst_err_o),
        .flush_i       (flush_i),
        .data_req_i    (data_req_i),
        .data_we_i     (data_we_i),
        .data_wstrb_i  (data_wstrb_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .ram_en_o      (ram_en_o),
        .ram_we_o      (ram_we_o),
        .ram_addr_o    (ram_addr_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_rdata_i   (ram_rdata_i)
    );

    always #5 clock = ~clock;

    // Synchronous RAM with one-cycle read latency; bd_* is a bench-side preload port.
    always @(posedge clock) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (ram_en_o && ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
        if (ram_en_o && !ram_we_o) ram_rdata_i <= mem[ram_addr_o];
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req_i = 0; inst_addr_i = Base; flush_i = 0;
        data_req_i = 0; data_we_i = 0; data_wstrb_i = 0; data_addr_i = Base; data_wdata_i = 0;
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        bd_we = 1; bd_idx = Log2'(idx); bd_data = val;
        cyc();
        bd_we = 0;
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        longint ua, ub;
        ua = longint'(a);
        ub = longint'(Base);
        return (a % 4 != 0) || (ua < ub) || (ua - ub >= 4 * longint'(Depth));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] ow, input logic [31:0] nw,
                                          input logic [3:0] st);
        logic [31:0] res;
        res = 0;
        for (int b = 0; b < 4; b++) begin
            res = res | ((((st[b] ? nw : ow) >> (8 * b)) & 32'hff) << (8 * b));
        end
        return res;
    endfunction

    function automatic logic [31:0] gen_addr();
        int unsigned r;
        r = $urandom_range(0, 15);
        case (r)
            0: return Base - 32'd4;
            1: return Base + 32'(4 * Depth) + 4 * $urandom_range(0, 3);
            2: return Base + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
            default: return Base + 4 * $urandom_range(0, 15);
        endcase
    endfunction

    task automatic test_reset();
        reset = 1;
        inst_req_i = 1; inst_addr_i = Base; data_req_i = 1; data_addr_i = Base + 4;
        cyc();
        @(negedge clock);
        vectors++;
        if ({inst_gnt_o, data_gnt_o, ram_en_o, ram_we_o, inst_rvalid_o, data_rvalid_o,
             inst_err_o, data_err_o} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 00000000", {inst_gnt_o, data_gnt_o,
                     ram_en_o, ram_we_o, inst_rvalid_o, data_rvalid_o, inst_err_o, data_err_o});
        end
        vectors++;
        if ({inst_rdata_o, data_rdata_o, ram_wdata_o, ram_addr_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h %h %h want all 0", inst_rdata_o, data_rdata_o,
                     ram_wdata_o, ram_addr_o);
        end
        cyc();
        reset = 0;
        idle_inputs();
        cyc();
    endtask

    task automatic test_fetch();
        poke(2, 32'h0280_0c0c);
        inst_req_i = 1; inst_addr_i = Base + 8;
        @(negedge clock);
        vectors++;
        if (inst_gnt_o !== 1'b1) begin
            miscompares++; $display("FAIL fetch_gnt: got %b want 1", inst_gnt_o);
        end
        vectors++;
        if ({ram_en_o, ram_we_o, ram_addr_o} !== {1'b1, 1'b0, 8'd2}) begin
            miscompares++;
            $display("FAIL fetch_ram: got en=%b we=%b addr=%0d want en=1 we=0 addr=2",
                     ram_en_o, ram_we_o, ram_addr_o);
        end
        cyc();
        inst_req_i = 0;
        @(negedge clock);
        vectors++;
        if ({inst_rvalid_o, inst_err_o, inst_rdata_o} !== {1'b1, 1'b0, 32'h0280_0c0c}) begin
            miscompares++;
            $display("FAIL fetch_resp: got rv=%b err=%b data=%h want rv=1 err=0 data=02800c0c",
                     inst_rvalid_o, inst_err_o, inst_rdata_o);
        end
        cyc();
    endtask

    task automatic test_starvation();
        inst_req_i = 1; inst_addr_i = Base + 4;
        data_req_i = 1; data_we_i = 0; data_addr_i = Base + 16;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            vectors++;
            if ({inst_gnt_o, data_gnt_o} !== ((c == 4) ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL starve_c%0d: got inst=%b data=%b want inst=%b data=%b", c,
                         inst_gnt_o, data_gnt_o, c == 4, c != 4);
            end
            cyc();
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_rmw();
        poke(5, 32'h1122_3344);
        inst_req_i = 1; inst_addr_i = Base;
        data_req_i = 1; data_we_i = 1; data_wstrb_i = 4'b0011;
        data_wdata_i = 32'hAAAA_BBBB; data_addr_i = Base + 20;
        @(negedge clock);
        vectors++;
        if ({inst_gnt_o, data_gnt_o, ram_en_o, ram_we_o, ram_addr_o} !==
            {1'b0, 1'b1, 1'b1, 1'b0, 8'd5}) begin
            miscompares++;
            $display("FAIL rmw_read: got ig=%b dg=%b en=%b we=%b addr=%0d want 0 1 1 0 5",
                     inst_gnt_o, data_gnt_o, ram_en_o, ram_we_o, ram_addr_o);
        end
        cyc();
        data_req_i = 0; data_we_i = 0;
        @(negedge clock);
        vectors++;
        if ({inst_gnt_o, data_gnt_o, ram_en_o, ram_we_o, ram_addr_o, data_rvalid_o, data_err_o}
            !== {1'b0, 1'b0, 1'b1, 1'b1, 8'd5, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rmw_write: got ig=%b dg=%b en=%b we=%b addr=%0d rv=%b err=%b want 0 0 1 1 5 1 0",
                     inst_gnt_o, data_gnt_o, ram_en_o, ram_we_o, ram_addr_o, data_rvalid_o,
                     data_err_o);
        end
        vectors++;
        if (ram_wdata_o !== 32'h1122_BBBB) begin
            miscompares++; $display("FAIL rmw_wdata: got %h want 1122bbbb", ram_wdata_o);
        end
        cyc();
        inst_req_i = 0;
        vectors++;
        if (mem[5] !== 32'h1122_BBBB) begin
            miscompares++; $display("FAIL rmw_mem: got %h want 1122bbbb", mem[5]);
        end
        cyc();
    endtask

    task automatic test_flush();
        inst_req_i = 1; inst_addr_i = Base + 8;
        @(negedge clock);
        vectors++;
        if (inst_gnt_o !== 1'b1) begin
            miscompares++; $display("FAIL flush_gnt: got %b want 1", inst_gnt_o);
        end
        cyc();
        flush_i = 1;
        data_req_i = 1; data_we_i = 0; data_addr_i = Base + 8;
        @(negedge clock);
        vectors++;
        if ({inst_gnt_o, inst_rvalid_o, inst_rdata_o, data_gnt_o} !== {1'b0, 1'b0, 32'h0, 1'b1})
        begin
            miscompares++;
            $display("FAIL flush_kill: got ig=%b rv=%b data=%h dg=%b want 0 0 00000000 1",
                     inst_gnt_o, inst_rvalid_o, inst_rdata_o, data_gnt_o);
        end
        cyc();
        idle_inputs();
        @(negedge clock);
        vectors++;
        if ({inst_rvalid_o, data_rvalid_o, data_rdata_o} !== {1'b0, 1'b1, 32'h0280_0c0c}) begin
            miscompares++;
            $display("FAIL flush_after: got irv=%b drv=%b ddata=%h want 0 1 02800c0c",
                     inst_rvalid_o, data_rvalid_o, data_rdata_o);
        end
        cyc();
    endtask

    task automatic test_addr_err();
        logic [31:0] bad [3];
        bad[0] = 32'h1bff_fffc; bad[1] = 32'h1c00_0002; bad[2] = Base + 32'(4 * Depth);
        for (int k = 0; k < 3; k++) begin
            data_req_i = 1; data_we_i = 0; data_addr_i = bad[k];
            @(negedge clock);
            vectors++;
            if ({data_gnt_o, ram_en_o} !== 2'b10) begin
                miscompares++;
                $display("FAIL aerr_gnt%0d: got gnt=%b en=%b want gnt=1 en=0", k, data_gnt_o,
                         ram_en_o);
            end
            cyc();
            data_req_i = 0;
            @(negedge clock);
            vectors++;
            if ({data_rvalid_o, data_err_o, data_rdata_o} !== {1'b1, 1'b1, 32'h0}) begin
                miscompares++;
                $display("FAIL aerr_resp%0d: got rv=%b err=%b data=%h want 1 1 00000000", k,
                         data_rvalid_o, data_err_o, data_rdata_o);
            end
            cyc();
        end
        inst_req_i = 1; inst_addr_i = Base + 1;
        @(negedge clock);
        vectors++;
        if ({inst_gnt_o, ram_en_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL ierr_gnt: got gnt=%b en=%b want gnt=1 en=0", inst_gnt_o, ram_en_o);
        end
        cyc();
        inst_req_i = 0;
        @(negedge clock);
        vectors++;
        if ({inst_rvalid_o, inst_err_o, inst_rdata_o} !== {1'b1, 1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL ierr_resp: got rv=%b err=%b data=%h want 1 1 00000000",
                     inst_rvalid_o, inst_err_o, inst_rdata_o);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) poke(8 + k, 32'hB0B0_0000 + 32'(k));
        for (int k = 0; k < 5; k++) begin
            data_req_i = (k < 4); data_we_i = 0; data_addr_i = Base + 32'(4 * (8 + k));
            @(negedge clock);
            vectors++;
            if ({data_gnt_o, data_rvalid_o} !== {k < 4, k > 0}) begin
                miscompares++;
                $display("FAIL b2b_ctl%0d: got gnt=%b rv=%b want gnt=%b rv=%b", k, data_gnt_o,
                         data_rvalid_o, k < 4, k > 0);
            end
            if (k > 0) begin
                vectors++;
                if (data_rdata_o !== 32'hB0B0_0000 + 32'(k - 1)) begin
                    miscompares++;
                    $display("FAIL b2b_data%0d: got %h want %h", k, data_rdata_o,
                             32'hB0B0_0000 + 32'(k - 1));
                end
            end
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_rmw();
        poke(6, 32'h5566_7788);
        data_req_i = 1; data_we_i = 1; data_wstrb_i = 4'b1100;
        data_wdata_i = 32'hDEAD_BEEF; data_addr_i = Base + 24;
        @(negedge clock);
        vectors++;
        if (data_gnt_o !== 1'b1) begin
            miscompares++; $display("FAIL rstrmw_gnt: got %b want 1", data_gnt_o);
        end
        cyc();
        idle_inputs();
        reset = 1;
        @(negedge clock);
        vectors++;
        if ({ram_en_o, ram_we_o, data_rvalid_o, data_gnt_o, inst_gnt_o, inst_rvalid_o} !== 6'b0)
        begin
            miscompares++;
            $display("FAIL rstrmw_abort: got en=%b we=%b drv=%b dg=%b ig=%b irv=%b want all 0",
                     ram_en_o, ram_we_o, data_rvalid_o, data_gnt_o, inst_gnt_o, inst_rvalid_o);
        end
        cyc();
        reset = 0;
        data_req_i = 1; data_we_i = 0; data_addr_i = Base + 24;
        @(negedge clock);
        vectors++;
        if ({data_gnt_o, ram_we_o, data_rvalid_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL rstrmw_idle: got gnt=%b we=%b rv=%b want 1 0 0", data_gnt_o,
                     ram_we_o, data_rvalid_o);
        end
        cyc();
        data_req_i = 0;
        @(negedge clock);
        vectors++;
        if (data_rdata_o !== 32'h5566_7788) begin
            miscompares++; $display("FAIL rstrmw_mem: got %h want 55667788", data_rdata_o);
        end
        cyc();
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [16];
        int starve;
        bit busy, p_i, p_ie, p_d, p_de;
        logic [31:0] p_id, p_dd;
        bit ierr, derr, e_ig, e_dg, e_en, e_irv;
        logic [31:0] e_ird;
        int iidx, didx;

        for (int k = 0; k < 16; k++) begin
            ref_mem[k] = $urandom();
            poke(k, ref_mem[k]);
        end
        starve = 0; busy = 0; p_i = 0; p_ie = 0; p_d = 0; p_de = 0; p_id = 0; p_dd = 0;

        for (int n = 0; n < 400; n++) begin
            inst_req_i   = ($urandom_range(0, 3) != 0);
            inst_addr_i  = gen_addr();
            flush_i      = ($urandom_range(0, 5) == 0);
            data_req_i   = 1'($urandom_range(0, 1));
            data_we_i    = 1'($urandom_range(0, 1));
            data_wstrb_i = 4'($urandom_range(0, 15));
            data_wdata_i = $urandom();
            data_addr_i  = gen_addr();

            ierr = is_bad(inst_addr_i);
            derr = is_bad(data_addr_i);
            iidx = int'((inst_addr_i - Base) >> 2) % 16;
            didx = int'((data_addr_i - Base) >> 2) % 16;
            if (busy) begin
                e_ig = 0; e_dg = 0;
            end else begin
                e_ig = inst_req_i && !flush_i && (starve == Limit || !data_req_i);
                e_dg = data_req_i && !e_ig;
            end
            e_en = busy || (e_ig && !ierr) ||
                   (e_dg && !derr && !(data_we_i && data_wstrb_i == 4'b0000));
            e_irv = p_i && !flush_i;
            e_ird = (e_irv && !p_ie) ? p_id : 32'h0;

            @(negedge clock);
            vectors++;
            if ({inst_gnt_o, data_gnt_o, ram_en_o, inst_rvalid_o, inst_err_o, data_rvalid_o,
                 data_err_o} !== {e_ig, e_dg, e_en, e_irv, e_irv && p_ie, p_d, p_d && p_de})
            begin
                miscompares++;
                $display("FAIL rnd_ctl n=%0d: got ig dg en irv ierr drv derr=%b want %b", n,
                         {inst_gnt_o, data_gnt_o, ram_en_o, inst_rvalid_o, inst_err_o,
                          data_rvalid_o, data_err_o},
                         {e_ig, e_dg, e_en, e_irv, e_irv && p_ie, p_d, p_d && p_de});
            end
            vectors++;
            if (inst_rdata_o !== e_ird) begin
                miscompares++;
                $display("FAIL rnd_irdata n=%0d: got %h want %h", n, inst_rdata_o, e_ird);
            end
            vectors++;
            if (data_rdata_o !== p_dd) begin
                miscompares++;
                $display("FAIL rnd_drdata n=%0d: got %h want %h", n, data_rdata_o, p_dd);
            end

            p_i  = e_ig;
            p_ie = ierr;
            p_id = (e_ig && !ierr) ? ref_mem[iidx] : 32'h0;
            p_d  = e_dg;
            p_de = derr;
            p_dd = (e_dg && !data_we_i && !derr) ? ref_mem[didx] : 32'h0;
            if (e_dg && data_we_i && !derr) begin
                ref_mem[didx] = merge(ref_mem[didx], data_wdata_i, data_wstrb_i);
            end
            busy = e_dg && data_we_i && !derr && data_wstrb_i != 4'b0000 &&
                   data_wstrb_i != 4'b1111;
            starve = (!inst_req_i || e_ig) ? 0 : ((starve < Limit) ? starve + 1 : Limit);
            cyc();
        end
        idle_inputs();
        cyc();
        cyc();
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (mem[k] !== ref_mem[k]) begin
                miscompares++;
                $display("FAIL rnd_mem%0d: got %h want %h", k, mem[k], ref_mem[k]);
            end
        end
    endtask

    initial begin
        clock = 0;
        reset = 1;
        bd_we = 0; bd_idx = '0; bd_data = '0;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_fetch();
        test_starvation();
        test_rmw();
        test_flush();
        test_addr_err();
        test_back_to_back();
        test_reset_in_rmw();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
